// File: rtl/seg_stopwatch_ctrl_pkg.sv
// rtl/seg_stopwatch_ctrl_pkg.sv - shared state encodings and display constants for the stopwatch
package seg_stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam logic [5:0] DP_CENTI = 6'b000_100;

  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/seg_stopwatch_ctrl_tick_gen.sv
// rtl/seg_stopwatch_ctrl_tick_gen.sv - 10 ms tick divider, held at zero while disabled
module tick_gen_10ms
  import seg_stopwatch_ctrl_pkg::*;
#(
  parameter logic [22:0] MAX = 23'd499_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  output logic tick
);

  logic [22:0] r_cnt;
  logic        r_tick;

  // Disabling restarts the divider so a resumed count gets a full period.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == MAX) ? '0 : r_cnt + 23'd1;
      r_tick <= (r_cnt == MAX - 23'd1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/seg_stopwatch_ctrl.sv
// rtl/seg_stopwatch_ctrl.sv - stopwatch FSM, elapsed/lap registers and display outputs
module seg_stopwatch_ctrl
  import seg_stopwatch_ctrl_pkg::*;
#(
  parameter logic [22:0] cnt_10ms_MAX = 23'd499_999,
  parameter logic [19:0] data_MAX     = 20'd999_999,
  parameter logic [6:0]  BLINK_TICKS  = 7'd50
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        key_start_stop,
  input  logic        key_lap,
  input  logic        key_clear,
  output logic [19:0] data,
  output logic [5:0]  dp,
  output logic        sign,
  output logic        seg_en,
  output logic        running
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_tick;
  logic        w_blink_tick;
  logic        w_counting;
  logic        w_sat;
  logic [19:0] r_elapsed;
  logic [19:0] r_lap_val;
  logic [19:0] r_data;
  logic [5:0]  r_dp;
  logic        r_seg_en;
  logic        r_running;
  logic [6:0]  r_blink_cnt;

  assign w_counting = is_counting(r_state);
  assign w_sat      = (r_elapsed == data_MAX);

  tick_gen_10ms #(.MAX(cnt_10ms_MAX)) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (w_counting),
    .tick    (w_tick)
  );

  tick_gen_10ms #(.MAX(cnt_10ms_MAX)) u_blink_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (1'b1),
    .tick    (w_blink_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // clear > start_stop > lap; a lower-priority key is dropped even if the higher one is ignored.
  always_comb begin
    w_state_nxt = r_state;
    if (key_clear) begin
      w_state_nxt = ST_IDLE;
    end else if (key_start_stop) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: if (!w_sat) w_state_nxt = ST_RUN;
        ST_LAP:   if (!w_sat) w_state_nxt = ST_PAUSE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end else if (key_lap && !w_sat) begin
      if (r_state == ST_RUN)      w_state_nxt = ST_LAP;
      else if (r_state == ST_LAP) w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_elapsed   <= '0;
      r_lap_val   <= '0;
      r_data      <= '0;
      r_dp        <= '0;
      r_seg_en    <= 1'b0;
      r_running   <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      if (w_state_nxt == ST_IDLE)
        r_elapsed <= '0;
      else if (w_tick && w_counting && !w_sat)
        r_elapsed <= r_elapsed + 20'd1;

      if (r_state == ST_RUN && w_state_nxt == ST_LAP)
        r_lap_val <= r_elapsed;

      if (r_state == ST_IDLE)     r_data <= '0;
      else if (r_state == ST_LAP) r_data <= r_lap_val;
      else                        r_data <= r_elapsed;

      r_dp      <= (r_state == ST_IDLE) ? 6'b000_000 : DP_CENTI;
      r_running <= is_counting(w_state_nxt);

      // Blink only while staying in PAUSE, so entry and exit both leave the display lit.
      if (r_state == ST_PAUSE && w_state_nxt == ST_PAUSE) begin
        if (w_blink_tick) begin
          if (r_blink_cnt == BLINK_TICKS - 7'd1) begin
            r_blink_cnt <= '0;
            r_seg_en    <= ~r_seg_en;
          end else begin
            r_blink_cnt <= r_blink_cnt + 7'd1;
          end
        end
      end else begin
        r_blink_cnt <= '0;
        r_seg_en    <= 1'b1;
      end
    end
  end

  assign data    = r_data;
  assign dp      = r_dp;
  assign sign    = 1'b0;
  assign seg_en  = r_seg_en;
  assign running = r_running;

endmodule

// File: tb/tb_seg_stopwatch_ctrl.sv
// tb/tb_seg_stopwatch_ctrl.sv - directed self-checking bench for seg_stopwatch_ctrl
module tb_seg_stopwatch_ctrl;

  logic        sys_clk;
  logic        sys_rst;
  logic        k_ss, k_lap, k_clr;
  logic [19:0] data;
  logic [5:0]  dp;
  logic        sign, seg_en, running;

  logic        s_ss, s_lap, s_clr;
  logic [19:0] s_data;
  logic [5:0]  s_dp;
  logic        s_sign, s_seg_en, s_running;

  int n_checks;
  int n_errors;

  seg_stopwatch_ctrl #(
    .cnt_10ms_MAX (23'd9),
    .data_MAX     (20'd999_999),
    .BLINK_TICKS  (7'd3)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .key_start_stop (k_ss),
    .key_lap        (k_lap),
    .key_clear      (k_clr),
    .data           (data),
    .dp             (dp),
    .sign           (sign),
    .seg_en         (seg_en),
    .running        (running)
  );

  seg_stopwatch_ctrl #(
    .cnt_10ms_MAX (23'd9),
    .data_MAX     (20'd12),
    .BLINK_TICKS  (7'd3)
  ) dut_sat (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .key_start_stop (s_ss),
    .key_lap        (s_lap),
    .key_clear      (s_clr),
    .data           (s_data),
    .dp             (s_dp),
    .sign           (s_sign),
    .seg_en         (s_seg_en),
    .running        (s_running)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_ss();
    k_ss = 1'b1; step(1); k_ss = 1'b0;
  endtask

  task automatic pulse_lap();
    k_lap = 1'b1; step(1); k_lap = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    step(3);
    sys_rst = 1'b0;
    n_checks++; if (data !== 20'd0) begin n_errors++; $display("FAIL por_data: got %0d expected 0", data); end
    n_checks++; if (seg_en !== 1'b0) begin n_errors++; $display("FAIL por_seg_en: got %0b expected 0", seg_en); end
    n_checks++; if (sign !== 1'b0) begin n_errors++; $display("FAIL por_sign: got %0b expected 0", sign); end
    step(1);
    n_checks++; if (seg_en !== 1'b1) begin n_errors++; $display("FAIL por_seg_en_on: got %0b expected 1", seg_en); end
    pulse_ss();
    step(30);
    n_checks++; if (data !== 20'd2) begin n_errors++; $display("FAIL pre_rst_data: got %0d expected 2", data); end
    sys_rst = 1'b1;
    step(3);
    sys_rst = 1'b0;
    n_checks++; if (data !== 20'd0) begin n_errors++; $display("FAIL rst_data: got %0d expected 0", data); end
    n_checks++; if (dp !== 6'b000_000) begin n_errors++; $display("FAIL rst_dp: got %b expected 000000", dp); end
    n_checks++; if (seg_en !== 1'b0) begin n_errors++; $display("FAIL rst_seg_en: got %0b expected 0", seg_en); end
    n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL rst_running: got %0b expected 0", running); end
    step(1);
    n_checks++; if (seg_en !== 1'b1) begin n_errors++; $display("FAIL rst_seg_en_on: got %0b expected 1", seg_en); end
    n_checks++; if (dp !== 6'b000_000) begin n_errors++; $display("FAIL idle_dp: got %b expected 000000", dp); end
  endtask

  task automatic test_run_pause();
    int n;
    pulse_ss();
    step(250);
    n_checks++; if (data !== 20'd24) begin n_errors++; $display("FAIL run_data_24: got %0d expected 24", data); end
    step(1);
    n_checks++; if (data !== 20'd25) begin n_errors++; $display("FAIL run_data_25: got %0d expected 25", data); end
    n_checks++; if (dp !== 6'b000_100) begin n_errors++; $display("FAIL run_dp: got %b expected 000100", dp); end
    n_checks++; if (running !== 1'b1) begin n_errors++; $display("FAIL run_running: got %0b expected 1", running); end
    pulse_ss();
    n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL pause_running: got %0b expected 0", running); end
    n_checks++; if (seg_en !== 1'b1) begin n_errors++; $display("FAIL pause_entry_seg_en: got %0b expected 1", seg_en); end
    step(1);
    n_checks++; if (data !== 20'd25) begin n_errors++; $display("FAIL pause_data: got %0d expected 25", data); end
    n = 0;
    while (seg_en === 1'b1 && n < 45) begin step(1); n++; end
    n_checks++; if (seg_en !== 1'b0) begin n_errors++; $display("FAIL blink_first_off: got %0b expected 0 within 45 cycles", seg_en); end
    n = 0;
    while (seg_en === 1'b0 && n < 60) begin step(1); n++; end
    n_checks++; if (n != 30) begin n_errors++; $display("FAIL blink_low_len: got %0d cycles expected 30", n); end
    n = 0;
    while (seg_en === 1'b1 && n < 60) begin step(1); n++; end
    n_checks++; if (n != 30) begin n_errors++; $display("FAIL blink_high_len: got %0d cycles expected 30", n); end
    n_checks++; if (data !== 20'd25) begin n_errors++; $display("FAIL pause_hold: got %0d expected 25", data); end
  endtask

  task automatic test_clear_priority();
    k_clr = 1'b1; k_ss = 1'b1;
    step(1);
    k_clr = 1'b0; k_ss = 1'b0;
    n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL clr_running: got %0b expected 0", running); end
    n_checks++; if (seg_en !== 1'b1) begin n_errors++; $display("FAIL clr_seg_en: got %0b expected 1", seg_en); end
    step(1);
    n_checks++; if (data !== 20'd0) begin n_errors++; $display("FAIL clr_data: got %0d expected 0", data); end
    n_checks++; if (dp !== 6'b000_000) begin n_errors++; $display("FAIL clr_dp: got %b expected 000000", dp); end
    pulse_lap();
    step(1);
    n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL idle_lap_running: got %0b expected 0", running); end
  endtask

  task automatic test_lap();
    int n;
    pulse_ss();
    n = 0;
    while (data !== 20'd40 && n < 600) begin step(1); n++; end
    n_checks++; if (data !== 20'd40) begin n_errors++; $display("FAIL lap_wait_40: got %0d expected 40 within 600 cycles", data); end
    pulse_lap();
    step(1);
    n_checks++; if (data !== 20'd40) begin n_errors++; $display("FAIL lap_data: got %0d expected 40", data); end
    n_checks++; if (running !== 1'b1) begin n_errors++; $display("FAIL lap_running: got %0b expected 1", running); end
    step(99);
    n_checks++; if (data !== 20'd40) begin n_errors++; $display("FAIL lap_frozen: got %0d expected 40", data); end
    pulse_lap();
    step(1);
    n_checks++; if (data !== 20'd50) begin n_errors++; $display("FAIL lap_release: got %0d expected 50", data); end
  endtask

  task automatic test_back_to_back();
    k_ss = 1'b1; k_lap = 1'b1;
    step(1);
    k_ss = 1'b0; k_lap = 1'b0;
    n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL b2b_running: got %0b expected 0", running); end
    step(1);
    n_checks++; if (data !== 20'd50) begin n_errors++; $display("FAIL b2b_data: got %0d expected 50", data); end
    pulse_lap();
    step(2);
    n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL pause_lap_running: got %0b expected 0", running); end
    n_checks++; if (data !== 20'd50) begin n_errors++; $display("FAIL pause_lap_data: got %0d expected 50", data); end
    pulse_ss();
    n_checks++; if (running !== 1'b1) begin n_errors++; $display("FAIL resume_running: got %0b expected 1", running); end
  endtask

  task automatic test_saturation();
    s_ss = 1'b1; step(1); s_ss = 1'b0;
    step(120);
    n_checks++; if (s_data !== 20'd11) begin n_errors++; $display("FAIL sat_data_11: got %0d expected 11", s_data); end
    step(1);
    n_checks++; if (s_data !== 20'd12) begin n_errors++; $display("FAIL sat_data_12: got %0d expected 12", s_data); end
    step(60);
    n_checks++; if (s_data !== 20'd12) begin n_errors++; $display("FAIL sat_hold: got %0d expected 12", s_data); end
    n_checks++; if (s_running !== 1'b1) begin n_errors++; $display("FAIL sat_running: got %0b expected 1", s_running); end
    s_ss = 1'b1; step(1); s_ss = 1'b0;
    n_checks++; if (s_running !== 1'b0) begin n_errors++; $display("FAIL sat_pause: got %0b expected 0", s_running); end
    s_ss = 1'b1; step(1); s_ss = 1'b0;
    n_checks++; if (s_running !== 1'b0) begin n_errors++; $display("FAIL sat_resume_ignored: got %0b expected 0", s_running); end
    step(1);
    n_checks++; if (s_data !== 20'd12) begin n_errors++; $display("FAIL sat_pause_data: got %0d expected 12", s_data); end
    s_clr = 1'b1; step(1); s_clr = 1'b0;
    step(1);
    n_checks++; if (s_data !== 20'd0) begin n_errors++; $display("FAIL sat_clear: got %0d expected 0", s_data); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    sys_rst  = 1'b1;
    k_ss = 1'b0; k_lap = 1'b0; k_clr = 1'b0;
    s_ss = 1'b0; s_lap = 1'b0; s_clr = 1'b0;
    test_reset();
    test_run_pause();
    test_clear_priority();
    test_lap();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
